// File: rtl/avalon_pio_pkg.sv
// Shared constants for the multi-channel display PIO: register addresses,
// CTRL bit positions and STATUS field offsets.
package avalon_pio_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'd8;
    localparam logic [3:0] ADDR_STATUS     = 4'd9;
    localparam logic [3:0] ADDR_BLINK_DIV  = 4'd10;
    localparam logic [3:0] ADDR_BLINK_MASK = 4'd11;

    localparam int CTRL_COMMIT   = 0;
    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_BLINK_EN = 2;

    localparam int STAT_PENDING    = 0;
    localparam int STAT_FSYNC      = 1;
    localparam int STAT_NUM_CH_LSB = 8;
    localparam int STAT_DATA_W_LSB = 16;

endpackage

// File: rtl/pio_blink_timer.sv
// Blink timer: a DIV_W-bit counter that toggles the blink phase every
// div_i+1 cycles while enabled.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable_i    : blink engine enable
//   div_i       : half-period minus one; zero stops the engine
//   div_wr_i    : divider being rewritten this cycle; restarts the count
//   phase_o     : registered blink phase (1 = blanked)
//   phase_d_o   : next-state phase, lets the parent register its output
//                 in the same edge as the phase flop
module pio_blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_wr_i,
    output logic             phase_o,
    output logic             phase_d_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable_i || div_i == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (div_wr_i) begin
            // A new divider restarts the count but keeps the current phase.
            cnt_d = '0;
        end else if (cnt_q == div_i) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o   = phase_q;
    assign phase_d_o = phase_d;

endmodule

// File: rtl/avalon_pio_multi_display.sv
// Avalon-MM slave driving NUM_CH display channels of DATA_W bits each.
// Software writes shadow registers; a COMMIT copies all of them to the
// active registers at once. A blink engine blanks BLINK_MASK bits of every
// channel during the blanked phase.
// Optional build macro PIO_FRAME_SYNC_EN: adds the frame_sync input and
// holds a pending commit until an edge where frame_sync is high.
//   clk, reset_n           : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     : Avalon-MM write side
//   readdata               : combinational read data, zero wait states
//   out_port               : channel i at [i*DATA_W +: DATA_W], registered
//   update_pulse           : high the cycle after the active registers change
//   blink_phase            : current blink phase (1 = blanked)
//   frame_sync (optional)  : commit strobe for tear-free updates
module avalon_pio_multi_display
    import avalon_pio_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 16,
    parameter int                DIV_W     = 24,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     update_pulse,
    output logic                     blink_phase
`ifdef PIO_FRAME_SYNC_EN
    ,
    input  logic                     frame_sync
`endif
);

    logic [DATA_W-1:0]        shadow_q [NUM_CH];
    logic [DATA_W-1:0]        shadow_d [NUM_CH];
    logic [DATA_W-1:0]        active_q [NUM_CH];
    logic [DATA_W-1:0]        active_d [NUM_CH];
    logic                     pending_q, pending_d;
    logic                     auto_q, auto_d;
    logic                     blink_en_q, blink_en_d;
    logic                     upd_q, upd_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [DATA_W-1:0]        mask_q, mask_d;
    logic [NUM_CH*DATA_W-1:0] out_q, out_d;

    logic wr_en, shadow_wr, commit_wr, div_wr, apply;
    logic phase_d;
    logic unused_wdata;

    assign unused_wdata = ^writedata;

    assign wr_en     = chipselect & ~write_n;
    assign shadow_wr = wr_en && (address < 4'(NUM_CH));
    assign commit_wr = wr_en && (address == ADDR_CTRL) && writedata[CTRL_COMMIT];
    assign div_wr    = wr_en && (address == ADDR_BLINK_DIV);

`ifdef PIO_FRAME_SYNC_EN
    assign apply = pending_q & frame_sync;
    localparam logic FSYNC_FEATURE = 1'b1;
`else
    assign apply = pending_q;
    localparam logic FSYNC_FEATURE = 1'b0;
`endif

    pio_blink_timer #(.DIV_W(DIV_W)) u_blink (
        .clk       (clk),
        .rst_n     (reset_n),
        .enable_i  (blink_en_q),
        .div_i     (div_q),
        .div_wr_i  (div_wr),
        .phase_o   (blink_phase),
        .phase_d_o (phase_d)
    );

    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        auto_d     = auto_q;
        blink_en_d = blink_en_q;
        div_d      = div_q;
        mask_d     = mask_q;
        out_d      = '0;

        // A commit takes the pre-write shadow; a coincident shadow write
        // lands in shadow only and waits for the next commit.
        for (int i = 0; i < NUM_CH; i++) begin
            if (apply) begin
                active_d[i] = shadow_q[i];
            end else if (auto_q && shadow_wr && address == 4'(i)) begin
                active_d[i] = writedata[DATA_W-1:0];
            end
            if (shadow_wr && address == 4'(i)) begin
                shadow_d[i] = writedata[DATA_W-1:0];
            end
        end

        if (wr_en && address == ADDR_CTRL) begin
            auto_d     = writedata[CTRL_AUTO];
            blink_en_d = writedata[CTRL_BLINK_EN];
        end
        if (div_wr) begin
            div_d = writedata[DIV_W-1:0];
        end
        if (wr_en && address == ADDR_BLINK_MASK) begin
            mask_d = writedata[DATA_W-1:0];
        end

        // Re-arming while already pending is absorbed by the apply.
        pending_d = apply ? 1'b0 : (pending_q | commit_wr);
        upd_d     = apply | (auto_q & shadow_wr);

        // Output built from next-state values so it lands with them.
        for (int i = 0; i < NUM_CH; i++) begin
            out_d[i*DATA_W +: DATA_W] = active_d[i] & ~(mask_d & {DATA_W{phase_d}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
            pending_q  <= 1'b0;
            auto_q     <= 1'b0;
            blink_en_q <= 1'b0;
            upd_q      <= 1'b0;
            div_q      <= '0;
            mask_q     <= '0;
            out_q      <= {NUM_CH{RESET_VAL}};
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            auto_q     <= auto_d;
            blink_en_q <= blink_en_d;
            upd_q      <= upd_d;
            div_q      <= div_d;
            mask_q     <= mask_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == 4'(i)) begin
                readdata[DATA_W-1:0] = shadow_q[i];
            end
        end
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_AUTO]     = auto_q;
                readdata[CTRL_BLINK_EN] = blink_en_q;
            end
            ADDR_STATUS: begin
                readdata[STAT_PENDING]                  = pending_q;
                readdata[STAT_FSYNC]                    = FSYNC_FEATURE;
                readdata[STAT_NUM_CH_LSB +: 8]          = 8'(NUM_CH);
                readdata[STAT_DATA_W_LSB +: 8]          = 8'(DATA_W);
            end
            ADDR_BLINK_DIV:  readdata[DIV_W-1:0]  = div_q;
            ADDR_BLINK_MASK: readdata[DATA_W-1:0] = mask_q;
            default: ;
        endcase
    end

    assign out_port     = out_q;
    assign update_pulse = upd_q;

endmodule
